// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, optional parity (macro UART_RX_PARITY_EN).
// Latency: 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+P+1)*CLKS_PER_BIT cycles from line falling edge to data_valid.
// Backpressure: none; data_valid is a one-cycle pulse and data_out is overwritten by each completed frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [15:0]   CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  sync1;
    logic                  sync2;
    logic                  rx_prev;
    logic [1:0]            settle;
    logic                  settled;
    logic [15:0]           cnt;
    logic                  tick;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  fall;
    logic                  shift_en;
    logic                  frame_done;

    // Two-flop synchroniser; reset to the idle-high level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // Edge-detect history. The synchroniser's reset 1s are not real line
    // data, so history is held low until the chain carries real samples;
    // a line held low through reset release therefore cannot start a frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            settle  <= 2'd0;
            rx_prev <= 1'b0;
        end else begin
            if (!settled) begin
                settle <= settle + 2'd1;
            end
            rx_prev <= settled ? sync2 : 1'b0;
        end
    end

    assign settled = (settle == 2'd2);
    assign fall    = rx_prev & ~sync2;
    assign tick    = (state == START) ? (cnt == CNT_HALF) : (cnt == CNT_FULL);
    assign busy    = (state != IDLE);

    // Bit-period timer: restarts in IDLE and on every sampling point.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= 16'd0;
        end else if (state == IDLE || tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle sampling strobes.
    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // A line back high at mid-start is a glitch, not a frame.
                if (tick) begin
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;

    // Capture the received parity bit; checked against the data at stop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (state == PARITY && tick) begin
                par_bit <= sync2;
            end
            if (frame_done) begin
                par_err_q <= par_bit ^ (^shreg);
            end
        end
    end

    assign parity_error = par_err_q;
`else
    assign parity_error = 1'b0;
`endif

    // Data path: LSB-first shift, bit count, and frame completion outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            stop_error <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (shift_en) begin
                shreg   <= {sync2, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end
            if (frame_done) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
                stop_error <= ~sync2;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit period (legal range 4..65535).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port rx_in, input, 1, meaning the asynchronous serial line, idle high.
REQ-006 SHALL have port data_out, output, DATA_WIDTH, meaning the last received data word, LSB first on the line.
REQ-007 SHALL have port data_valid, output, 1, meaning a one-cycle pulse when data_out updates.
REQ-008 SHALL have port parity_error, output, 1, meaning the received parity bit mismatched the computed parity.
REQ-009 SHALL have port stop_error, output, 1, meaning the stop bit was sampled low (framing error).
REQ-010 SHALL have port busy, output, 1, meaning the receiver is high in any state other than IDLE.

Function
REQ-011 SHALL pass rx_in through a 2-flop synchronizer (reset value 1) before any use; all timing references the synchronized signal.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on a synchronized falling edge (previous 1, current 0).
REQ-013 SHALL, in START, count CLKS_PER_BIT/2 cycles (integer divide), then sample: if 0, go to DATA; if 1, treat it as a glitch, return to IDLE, and raise no flags.
REQ-014 SHALL, in DATA, sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB first, and leave after DATA_WIDTH samples; the bit counter wraps to 0 on exit.
REQ-015 SHALL, in PARITY (only when compiled in, per REQ-024), sample one bit after CLKS_PER_BIT cycles; the expected parity bit equals the XOR of all received data bits, so it is 1 when the count of 1s is odd.
REQ-016 SHALL, in STOP, sample after CLKS_PER_BIT cycles, then in that same cycle load data_out, pulse data_valid, update parity_error and stop_error, and return to IDLE.
REQ-017 SHALL update data_out and pulse data_valid even when stop_error or parity_error is set; the error flags hold until the next frame completes.
REQ-018 SHALL accept a new falling edge in IDLE on the cycle immediately after the return from STOP (back-to-back frames with no idle gap beyond the stop bit).
REQ-019 SHALL ignore rx_in edges while not in IDLE, except for the sampling points.
REQ-020 SHALL give a latency of 2 synchronizer cycles plus CLKS_PER_BIT/2 + (DATA_WIDTH+P+1)*CLKS_PER_BIT cycles from the line falling edge to data_valid, with P=1 if parity is compiled in, else 0.

Reset
REQ-021 SHALL, while reset==0 at a clk edge, force the state to IDLE, all counters to 0, the shift register to 0, data_out=0, data_valid=0, parity_error=0, stop_error=0, busy=0, and the synchronizer flops to 1.
REQ-022 SHALL, when reset is asserted mid-frame, abandon the frame with no data_valid pulse; after release, the receiver waits for a fresh falling edge.
REQ-023 SHALL exit reset without a spurious start if rx_in is low at release; a start needs a 1->0 transition after release.

Configuration
REQ-024 SHALL honour macro UART_RX_PARITY_EN: when defined, the PARITY state exists and the frame is start + DATA_WIDTH + parity + stop; when undefined, DATA goes directly to STOP, the frame has no parity bit, and parity_error is tied to 0.

Verification
REQ-025 SHALL cover a clean frame, parity enabled, CLKS_PER_BIT=16, data 0xA5 with parity bit 0 and stop 1 -> data_out=0xA5, one data_valid pulse, both errors 0.
REQ-026 SHALL cover a parity error: send 0x07 with parity bit 0 -> data_out=0x07, data_valid pulses, parity_error=1, stop_error=0.
REQ-027 SHALL cover a framing error: send 0x3C with the stop bit driven 0 -> data_valid pulses, stop_error=1, data_out=0x3C.
REQ-028 SHALL cover a glitch: a 4-cycle low pulse on an idle line -> no data_valid, busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-029 SHALL cover reset mid-frame: assert reset during DATA bit 3, release it, then send 0x5A -> only one data_valid pulse, for 0x5A.
REQ-030 SHALL cover back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses with values 0x00 and 0xFF, no errors.
